riscv_lsu: RTL and testbench

//  Memory-stage load/store unit of the pipelined core; the producer of the W-stage read data that writeback selects.

---
 rtl/riscv_lsu_pkg.sv | 25 ++
 rtl/riscv_lsu_align.sv | 34 +++
 rtl/riscv_lsu.sv | 111 +++++++++++
 tb/tb_riscv_lsu.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared widths, state codes and funct3 constants for the load/store unit
package riscv_lsu_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = XLEN / 8;

   localparam logic [0:0] LSU_IDLE = 1'b0;
   localparam logic [0:0] LSU_BUSY = 1'b1;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Access size comes from funct3[1:0] only; 011/110/111 fall into the word case.
   function automatic logic is_byte(input logic [2:0] funct3);
      return funct3[1:0] == 2'b00;
   endfunction

   function automatic logic is_half(input logic [2:0] funct3);
      return funct3[1:0] == 2'b01;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - load lane select and sign/zero extension
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // funct3[2] distinguishes the unsigned variants (LBU/LHU).
   always_comb begin
      data = rdata;
      if (is_byte(funct3)) begin
         data = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end else if (is_half(funct3)) begin
         data = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
   end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - memory-stage load/store unit with req/ack data-bus FSM and MEM/WB read-data register
module riscv_lsu
   import riscv_lsu_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_mem_read_m,
   input  logic            i_mem_write_m,
   input  logic [2:0]      i_funct3_m,
   input  logic [XLEN-1:0] i_alu_result_m,
   input  logic [XLEN-1:0] i_write_data_m,
   output logic            o_dbus_req,
   output logic            o_dbus_we,
   output logic [XLEN-1:0] o_dbus_addr,
   output logic [BE_W-1:0] o_dbus_be,
   output logic [XLEN-1:0] o_dbus_wdata,
   input  logic            i_dbus_ack,
   input  logic [XLEN-1:0] i_dbus_rdata,
   output logic [XLEN-1:0] o_read_data_w,
   output logic            o_stall_lsu,
   output logic            o_misaligned
);

   logic [0:0]      state;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic            mem_op;
   logic            mis;
   logic            acc;
   logic [1:0]      addr_lo;
   logic [BE_W-1:0] store_be;
   logic [XLEN-1:0] store_wdata;
   logic [XLEN-1:0] load_data;

   assign addr_lo = i_alu_result_m[1:0];
   assign mem_op  = i_mem_read_m | i_mem_write_m;

   always_comb begin
      mis = 1'b0;
      if (is_half(i_funct3_m)) begin
         mis = addr_lo[0];
      end else if (!is_byte(i_funct3_m)) begin
         mis = |addr_lo;
      end
   end

   assign o_misaligned = mem_op & mis;
   assign acc          = mem_op & ~mis;

   // The ack cycle releases the stall so the instruction leaves M on the same edge the bus completes.
   assign o_stall_lsu  = acc & ~((state == LSU_BUSY) & i_dbus_ack);

   always_comb begin
      store_be    = 4'b1111;
      store_wdata = i_write_data_m;
      if (is_byte(i_funct3_m)) begin
         store_be    = 4'b0001 << addr_lo;
         store_wdata = {4{i_write_data_m[7:0]}};
      end else if (is_half(i_funct3_m)) begin
         store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
         store_wdata = {2{i_write_data_m[15:0]}};
      end
   end

   riscv_lsu_align u_align (
      .rdata   (i_dbus_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .data    (load_data)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state         <= LSU_IDLE;
         o_dbus_req    <= 1'b0;
         o_dbus_we     <= 1'b0;
         o_dbus_addr   <= '0;
         o_dbus_be     <= '0;
         o_dbus_wdata  <= '0;
         funct3_q      <= '0;
         addr_lo_q     <= '0;
         o_read_data_w <= '0;
      end else begin
         case (state)
            LSU_IDLE: begin
               if (acc) begin
                  state        <= LSU_BUSY;
                  o_dbus_req   <= 1'b1;
                  o_dbus_we    <= i_mem_write_m;
                  o_dbus_addr  <= {i_alu_result_m[XLEN-1:2], 2'b00};
                  o_dbus_be    <= i_mem_write_m ? store_be : 4'b1111;
                  o_dbus_wdata <= i_mem_write_m ? store_wdata : '0;
                  funct3_q     <= i_funct3_m;
                  addr_lo_q    <= addr_lo;
               end
            end
            LSU_BUSY: begin
               if (i_dbus_ack) begin
                  state      <= LSU_IDLE;
                  o_dbus_req <= 1'b0;
                  if (!o_dbus_we) begin
                     o_read_data_w <= load_data;
                  end
               end
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard bench for riscv_lsu with a randomized bus responder
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] alu_result = 32'h0;
   logic [31:0] write_data = 32'h0;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack = 1'b0;
   logic [31:0] dbus_rdata = 32'h0;
   logic [31:0] read_data_w;
   logic        stall;
   logic        misaligned;

   riscv_lsu dut (
      .i_clk          (clk),
      .i_rstn         (rstn),
      .i_mem_read_m   (mem_read),
      .i_mem_write_m  (mem_write),
      .i_funct3_m     (funct3),
      .i_alu_result_m (alu_result),
      .i_write_data_m (write_data),
      .o_dbus_req     (dbus_req),
      .o_dbus_we      (dbus_we),
      .o_dbus_addr    (dbus_addr),
      .o_dbus_be      (dbus_be),
      .o_dbus_wdata   (dbus_wdata),
      .i_dbus_ack     (dbus_ack),
      .i_dbus_rdata   (dbus_rdata),
      .o_read_data_w  (read_data_w),
      .o_stall_lsu    (stall),
      .o_misaligned   (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [1:0]  alo;
   } exp_t;

   typedef struct {
      int          lat;
      logic [31:0] rd;
   } resp_t;

   exp_t  exp_q[$];
   resp_t rq[$];
   int    total = 0;
   int    bad = 0;
   int    n_issued = 0;
   int    n_acked = 0;
   bit    mon_en = 0;
   bit    auto_ack = 0;
   logic [31:0] model_rd = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
      case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         default: return a[1:0] != 2'b00;
      endcase
   endfunction

   function automatic exp_t model_txn(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.we = wr;
      e.addr = a & 32'hFFFF_FFFC;
      e.f3 = f3;
      e.alo = a[1:0];
      e.be = 4'hF;
      e.wdata = d;
      if (wr && f3[1:0] == 2'b00) begin
         e.be = 4'b0001 << a[1:0];
         e.wdata = {4{d[7:0]}};
      end else if (wr && f3[1:0] == 2'b01) begin
         e.be = 4'b0011 << (2 * a[1]);
         e.wdata = {2{d[15:0]}};
      end
      return e;
   endfunction

   function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
      logic [31:0] s;
      s = w >> (8 * a);
      case (f3[1:0])
         2'b00:   return f3[2] ? (s & 32'hFF) : {{24{s[7]}}, s[7:0]};
         2'b01:   return f3[2] ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]};
         default: return w;
      endcase
   endfunction

   // Bus responder: acks each request after the latency queued with it.
   initial begin
      resp_t cur;
      bit    have_cur = 0;
      int    cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (auto_ack) begin
            if (dbus_ack) begin
               dbus_ack = 1'b0;
            end else if (dbus_req) begin
               if (!have_cur) begin
                  if (rq.size() == 0) begin
                     cur.lat = 0;
                     cur.rd = $urandom;
                  end else begin
                     cur = rq.pop_front();
                  end
                  have_cur = 1;
                  cnt = 0;
               end
               if (cnt == cur.lat) begin
                  dbus_ack = 1'b1;
                  dbus_rdata = cur.rd;
                  have_cur = 0;
               end else begin
                  cnt++;
               end
            end
         end
      end
   end

   // Monitor: checks bus fields on every request cycle, retires on ack, tracks W-stage data.
   always @(negedge clk) begin
      if (mon_en) begin
         check("read_data_w", read_data_w, model_rd);
         if (!rstn) begin
            model_rd = 32'h0;
         end else if (dbus_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req", dbus_req, 1'b0);
            end else begin
               check("dbus_we", dbus_we, exp_q[0].we);
               check("dbus_addr", dbus_addr, exp_q[0].addr);
               check("dbus_be", dbus_be, exp_q[0].be);
               if (exp_q[0].we) check("dbus_wdata", dbus_wdata, exp_q[0].wdata);
               if (dbus_ack) begin
                  if (!exp_q[0].we) model_rd = model_ext(dbus_rdata, exp_q[0].f3, exp_q[0].alo);
                  void'(exp_q.pop_front());
                  n_acked++;
               end
            end
         end
      end
   end

   task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic [31:0] rdv);
      bit mis;
      int sc;
      @(posedge clk);
      #1;
      mem_read = rd;
      mem_write = wr;
      funct3 = f3;
      alu_result = a;
      write_data = d;
      mis = (rd | wr) && model_mis(f3, a);
      if ((rd | wr) && !mis) begin
         exp_q.push_back(model_txn(wr, f3, a, d));
         rq.push_back('{lat, rdv});
         n_issued++;
      end
      sc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) check("misaligned", misaligned, mis);
         if (!stall) break;
         sc++;
      end
      check("stall_cycles", sc, ((rd | wr) && !mis) ? lat + 1 : 0);
      if (mis) check("req_on_misaligned", dbus_req, 1'b0);
   endtask

   task automatic bubble();
      @(posedge clk);
      #1;
      mem_read = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      check("rst_req", dbus_req, 1'b0);
      check("rst_we", dbus_we, 1'b0);
      check("rst_addr", dbus_addr, 32'h0);
      check("rst_be", dbus_be, 4'h0);
      check("rst_wdata", dbus_wdata, 32'h0);
      check("rst_read_data", read_data_w, 32'h0);
      check("rst_stall", stall, 1'b0);
      mon_en = 1;
      auto_ack = 1;

      do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
      bubble();
      check("lw_data", read_data_w, 32'hDEADBEEF);

      do_op(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000);
      bubble();
      check("lb_data", read_data_w, 32'hFFFFFF80);
      do_op(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000);
      bubble();
      check("lbu_data", read_data_w, 32'h00000080);

      do_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'h0);
      bubble();
      check("sh_keeps_data", read_data_w, 32'h00000080);

      do_op(1, 0, 3'b010, 32'h104, 32'h0, 3, 32'h0BADF00D);
      bubble();
      check("lw_delayed_data", read_data_w, 32'h0BADF00D);

      do_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
      bubble();
      check("mis_keeps_data", read_data_w, 32'h0BADF00D);

      do_op(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h11223344);
      do_op(0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 0, 32'h0);
      bubble();
      check("b2b_data", read_data_w, 32'h11223344);

      for (int n = 0; n < 80; n++) begin
         int          kind;
         logic [2:0]  f3;
         logic [2:0]  load_f3s [8];
         load_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
         kind = $urandom_range(0, 3);
         if (kind == 3) f3 = 3'($urandom_range(0, 2));
         else f3 = load_f3s[$urandom_range(0, 7)];
         do_op(kind == 1 || kind == 2, kind == 3, f3, 32'h400 + $urandom_range(0, 255),
               $urandom, $urandom_range(0, 3), $urandom);
      end
      bubble();
      repeat (2) @(posedge clk);

      auto_ack = 0;
      #3;
      dbus_ack = 1'b0;
      @(posedge clk);
      #1;
      mem_read = 1'b1;
      funct3 = 3'b010;
      alu_result = 32'h500;
      exp_q.push_back(model_txn(0, 3'b010, 32'h500, 32'h0));
      @(posedge clk);
      #1;
      check("busy_req", dbus_req, 1'b1);
      rstn = 1'b0;
      mem_read = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      exp_q.delete();
      check("abort_req", dbus_req, 1'b0);
      dbus_ack = 1'b1;
      dbus_rdata = 32'h55AA55AA;
      @(posedge clk);
      #1;
      dbus_ack = 1'b0;
      check("late_ack_req", dbus_req, 1'b0);
      check("late_ack_data", read_data_w, 32'h0);
      check("late_ack_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      check("late_ack_idle", dbus_req, 1'b0);

      check("txn_count", n_acked, n_issued);
      check("queue_empty", exp_q.size(), 0);
      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
